// File: rtl/mul_arb_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
package mul_arb_pkg;

  localparam int MUL_WIDTH   = 32;
  localparam int MUL_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_arbiter_rr.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = valid0 & (~valid1 | last_grant);
  assign gnt1 = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external shift multiplier between two requesters, with a done-timeout.
//   state | meaning
//   IDLE  | waiting for a request; the only state that grants
//   START | one-cycle mul_start pulse, timeout timer loaded
//   BUSY  | waiting for mul_done or timer expiry
//   RESP  | result presented to the grantee until it takes it
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int WIDTH   = MUL_WIDTH,
  parameter int TIMEOUT = MUL_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp0_valid,
  output logic               rsp1_valid,
  input  logic               rsp0_ready,
  input  logic               rsp1_ready,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               rsp_err,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic          last_grant;
  logic          grant_id;
  logic [TW-1:0] timer;
  logic          gnt0;
  logic          gnt1;
  logic          rsp_take;

  rr_arbiter2 u_rr (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign req0_ready = ~rst & (state == ST_IDLE) & gnt0;
  assign req1_ready = ~rst & (state == ST_IDLE) & gnt1;
  assign rsp_take   = grant_id ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      timer       <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt0 | gnt1) begin
            grant_id  <= gnt1;
            mul_a     <= gnt1 ? req1_a : req0_a;
            mul_b     <= gnt1 ? req1_b : req0_b;
            mul_start <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          mul_start <= 1'b0;
          // Down-count: terminal count reached on the TIMEOUT-th BUSY cycle
          timer     <= TW'(TIMEOUT - 1);
          state     <= ST_BUSY;
        end
        ST_BUSY: begin
          if (mul_done || timer == '0) begin
            rsp_product <= mul_done ? mul_product : '0;
            rsp_err     <= ~mul_done;
            rsp0_valid  <= ~grant_id;
            rsp1_valid  <= grant_id;
            mul_a       <= '0;
            mul_b       <= '0;
            state       <= ST_RESP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_take) begin
            last_grant  <= grant_id;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp_product <= '0;
            rsp_err     <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: timeline reference model plus directed scenarios with literal results.
module tb_mul_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [63:0] rsp_product;
  logic        rsp_err, mul_start, mul_done;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_product;

  mul_arbiter #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 64'(sa * sb);
  endfunction

  // Multiplier model: done pulses mdl_delay cycles after mul_start; 0 means never.
  int          mdl_delay = 1;
  int          inject_cyc = -1;
  int          m_cnt = 0;
  logic [63:0] m_res = '0;

  initial begin
    mul_done    = 1'b0;
    mul_product = '0;
  end

  always @(posedge clk) begin
    #1;
    mul_done = 1'b0;
    if (rst_q) m_cnt = 0;
    else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mul_done    = 1'b1;
        mul_product = m_res;
      end
    end
    if (cyc == inject_cyc) begin
      mul_done    = 1'b1;
      mul_product = 64'h1234;
    end
    if (!rst_q && mul_start) begin
      m_cnt = mdl_delay;
      m_res = mul64(mul_a, mul_b);
    end
  end

  // Reference: one operation is a timeline fixed at accept time.
  logic        armed = 1'b0;
  logic        m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0, m_err = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [63:0] m_prod = '0;
  int          t_start, t_end, t_rsp;
  logic        e_r0, e_r1, in_resp, in_mul;
  int          n_start = 0;
  int          grant_log[$];
  int          rsp_id_q[$];
  logic [63:0] rsp_prod_q[$];
  logic        rsp_err_q[$];

  always @(negedge clk) begin
    if (rst_q) begin
      armed  = 1'b1;
      m_busy = 1'b0;
      m_last = 1'b1;
    end
    if (armed) begin
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (!rst && !m_busy) begin
        if (req0_valid && req1_valid) begin
          e_r0 = m_last;
          e_r1 = !m_last;
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
      end
      in_resp = m_busy && cyc >= t_rsp;
      in_mul  = m_busy && cyc >= t_start && cyc <= t_end;
      check("req0_ready", req0_ready, e_r0);
      check("req1_ready", req1_ready, e_r1);
      check("mul_start", mul_start, m_busy && cyc == t_start);
      check("mul_a", mul_a, in_mul ? m_a : 32'h0);
      check("mul_b", mul_b, in_mul ? m_b : 32'h0);
      check("rsp0_valid", rsp0_valid, in_resp && !m_id);
      check("rsp1_valid", rsp1_valid, in_resp && m_id);
      check("rsp_product", rsp_product, in_resp ? m_prod : 64'h0);
      check("rsp_err", rsp_err, in_resp && m_err);
      if (mul_start) n_start++;
      if (req0_ready && req0_valid) grant_log.push_back(0);
      if (req1_ready && req1_valid) grant_log.push_back(1);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        rsp_id_q.push_back(rsp1_valid ? 1 : 0);
        rsp_prod_q.push_back(rsp_product);
        rsp_err_q.push_back(rsp_err);
      end
      if (!rst) begin
        if (in_resp && (m_id ? rsp1_ready : rsp0_ready)) begin
          m_busy = 1'b0;
          m_last = m_id;
        end else if (e_r0 || e_r1) begin
          m_busy  = 1'b1;
          m_id    = e_r1;
          m_a     = e_r1 ? req1_a : req0_a;
          m_b     = e_r1 ? req1_b : req0_b;
          t_start = cyc + 1;
          if (mdl_delay >= 1 && mdl_delay <= TIMEOUT) begin
            t_end  = t_start + mdl_delay;
            m_prod = mul64(m_a, m_b);
            m_err  = 1'b0;
          end else begin
            t_end  = t_start + TIMEOUT;
            m_prod = '0;
            m_err  = 1'b1;
          end
          t_rsp = t_end + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_ctrl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, mul_start}, 64'h0);
    check("reset_product", rsp_product, 64'h0);
    check("reset_mul_ops", {mul_a, mul_b}, 64'h0);
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b, output int acc);
    logic got;
    got = 1'b0;
    acc = -1;
    if (k == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (k == 0 ? req0_ready : req1_ready) begin
        got = 1'b1;
        acc = cyc;
        break;
      end
    end
    if (!got) check("issue_grant_timeout", 64'd0, 64'd1);
    tick();
    if (k == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int k, input logic [63:0] p, input logic e, input string name, output int at);
    logic got;
    got = 1'b0;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (k == 0 ? rsp0_valid : rsp1_valid) begin
        got = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!got) check({name, "_rsp_timeout"}, 64'd0, 64'd1);
    else begin
      check({name, "_product"}, rsp_product, p);
      check({name, "_err"}, {63'd0, rsp_err}, {63'd0, e});
    end
    tick();
  endtask

  task automatic wait_rsp_count(input int n);
    for (int i = 0; i < 400 && rsp_id_q.size() < n; i++) tick();
    check("rsp_count", rsp_id_q.size(), n);
  endtask

  logic [31:0] t0a[3] = '{-32'sd7, 32'd100, -32'sd2000};
  logic [31:0] t0b[3] = '{32'd11, -32'sd3, -32'sd2000};
  logic [31:0] t1a[3] = '{32'd6, -32'sd1, 32'h7fffffff};
  logic [31:0] t1b[3] = '{32'd7, 32'd1, 32'd2};

  initial begin
    int ca, cr, bg, br, bs, n0, n1;
    logic g0, g1, found;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    reset_dut();

    // minimum latency
    mdl_delay = 1;
    issue(0, 32'd3, 32'd4, ca);
    wait_rsp(0, 64'd12, 1'b0, "min_lat", cr);
    check("min_latency", cr - ca, 3);

    // single request, long multiplier, req1 drops before being granted
    reset_dut();
    mdl_delay = 33;
    bg = grant_log.size();
    issue(0, 32'd5, -32'sd5, ca);
    req1_a = 32'd1; req1_b = 32'd1; req1_valid = 1'b1;
    repeat (3) tick();
    req1_valid = 1'b0;
    wait_rsp(0, 64'hFFFFFFFFFFFFFFE7, 1'b0, "neg25", cr);
    check("neg25_latency", cr - ca, 35);
    check("dropped_req_no_grant", grant_log.size() - bg, 1);

    // simultaneous requests after reset
    reset_dut();
    mdl_delay = 3;
    bg = grant_log.size(); br = rsp_id_q.size(); bs = n_start;
    req0_a = 32'd8; req0_b = 32'd6; req1_a = -32'sd12; req1_b = 32'd6;
    req0_valid = 1; req1_valid = 1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 300 && !(n0 == 1 && n1 == 1); i++) begin
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      tick();
      if (g0) begin req0_valid = 0; n0 = 1; end
      if (g1) begin req1_valid = 0; n1 = 1; end
    end
    wait_rsp_count(br + 2);
    check("tie_first_grant", grant_log[bg], 0);
    check("tie_second_grant", grant_log[bg + 1], 1);
    check("tie_rsp0_product", rsp_prod_q[br], 64'd48);
    check("tie_rsp1_id", rsp_id_q[br + 1], 1);
    check("tie_rsp1_product", rsp_prod_q[br + 1], 64'hFFFFFFFFFFFFFFB8);
    check("tie_start_pulses", n_start - bs, 2);

    // both held valid: strict alternation
    mdl_delay = 2;
    bg = grant_log.size(); br = rsp_id_q.size();
    n0 = 0; n1 = 0;
    req0_a = t0a[0]; req0_b = t0b[0]; req1_a = t1a[0]; req1_b = t1b[0];
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 500 && !(n0 == 3 && n1 == 3); i++) begin
      @(negedge clk);
      g0 = req0_ready; g1 = req1_ready;
      tick();
      if (g0) begin
        n0++;
        if (n0 < 3) begin req0_a = t0a[n0]; req0_b = t0b[n0]; end
        else req0_valid = 0;
      end
      if (g1) begin
        n1++;
        if (n1 < 3) begin req1_a = t1a[n1]; req1_b = t1b[n1]; end
        else req1_valid = 0;
      end
    end
    wait_rsp_count(br + 6);
    for (int i = 0; i < 6; i++) check("alt_grant", grant_log[bg + i], i % 2);
    check("alt_first_product", rsp_prod_q[br], 64'hFFFFFFFFFFFFFFB3);

    // timeout then recovery
    mdl_delay = 0;
    issue(1, -32'sd5, -32'sd5, ca);
    wait_rsp(1, 64'd0, 1'b1, "timeout", cr);
    check("timeout_latency", cr - ca, 66);
    mdl_delay = 4;
    issue(1, -32'sd5, -32'sd5, ca);
    wait_rsp(1, 64'd25, 1'b0, "after_timeout", cr);

    // response back-pressure with req1 pending
    rsp0_ready = 0;
    mdl_delay = 2;
    issue(0, 32'd7, 32'd9, ca);
    req1_a = 32'd3; req1_b = 32'd4; req1_valid = 1;
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp0_valid) begin found = 1; break; end
    end
    check("stall_rsp_seen", found, 1);
    tick();
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", rsp0_valid, 1);
      check("stall_product", rsp_product, 64'd63);
      check("stall_err", rsp_err, 0);
      check("stall_req1_ready", req1_ready, 0);
      tick();
    end
    rsp0_ready = 1;
    issue(1, 32'd3, 32'd4, ca);
    wait_rsp(1, 64'd12, 1'b0, "after_stall", cr);

    // reset during BUSY, late done afterwards
    mdl_delay = 20;
    issue(0, 32'd9, 32'd9, ca);
    repeat (4) tick();
    rst = 1;
    inject_cyc = cyc + 2;
    tick();
    rst = 0;
    repeat (6) begin
      @(negedge clk);
      check("rst_idle_ctrl", {rsp0_valid, rsp1_valid, rsp_err, mul_start, req0_ready, req1_ready}, 64'h0);
      check("rst_idle_product", rsp_product, 64'h0);
      check("rst_idle_mul_ops", {mul_a, mul_b}, 64'h0);
      tick();
    end
    mdl_delay = 3;
    issue(0, 32'd1, -32'sd5, ca);
    wait_rsp(0, 64'hFFFFFFFFFFFFFFFB, 1'b0, "after_reset", cr);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
